// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer beside the EX stage.
// A single shift-add / restoring-divide datapath runs 32 steps per operation.
// Divide-by-zero and signed overflow skip the iteration and finish straight from PREP.
module mdu_seq #(
    parameter int unsigned BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [BIT_W-1:0] rs1_i,
    input  logic [BIT_W-1:0] rs2_i,
    input  logic [4:0]       rd_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [BIT_W-1:0] result_o,
    output logic [4:0]       rd_o
);
    localparam int unsigned      CNT_W    = $clog2(BIT_W);
    localparam int unsigned      PROD_W   = 2 * BIT_W;
    localparam logic [BIT_W-1:0] MIN_NEG  = {1'b1, {(BIT_W-1){1'b0}}};
    localparam logic [BIT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d, rd_out_q, rd_out_d;
    logic [BIT_W-1:0]  a_q, a_d, b_q, b_d;
    logic [BIT_W-1:0]  mag_q, mag_d;          // multiplicand or divisor
    logic [PROD_W-1:0] prod_q, prod_d;        // {acc/remainder, multiplier/quotient}
    logic              neg_q, neg_d, a_neg_q, a_neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  result_q, result_d;

    logic              is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, div_ovf, div_ge;
    logic [BIT_W-1:0]  a_mag, b_mag, special_res, div_sub, quo, rem, fix_res;
    logic [BIT_W:0]    mul_sum, div_shift;
    logic [PROD_W-1:0] step_prod, prod_fix;

    // Operand signedness, magnitudes, single-step datapath and final result select
    always_comb begin
        is_div   = op_q[2];
        is_rem   = op_q[1];
        a_signed = (op_q == 3'd0) || (op_q == 3'd1) || (op_q == 3'd2) ||
                   (op_q == 3'd4) || (op_q == 3'd6);
        b_signed = (op_q == 3'd0) || (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
        a_neg    = a_signed && a_q[BIT_W-1];
        b_neg    = b_signed && b_q[BIT_W-1];
        a_mag    = a_neg ? -a_q : a_q;
        b_mag    = b_neg ? -b_q : b_q;

        div_zero = is_div && (b_q == '0);
        div_ovf  = is_div && !op_q[0] && (a_q == MIN_NEG) && (b_q == ALL_ONES);
        if (div_zero) begin
            special_res = is_rem ? a_q : ALL_ONES;
        end else begin
            special_res = is_rem ? '0 : MIN_NEG;
        end

        mul_sum   = {1'b0, prod_q[PROD_W-1:BIT_W]} + (prod_q[0] ? {1'b0, mag_q} : '0);
        div_shift = {prod_q[PROD_W-1:BIT_W], prod_q[BIT_W-1]};
        div_ge    = div_shift >= {1'b0, mag_q};
        div_sub   = div_shift[BIT_W-1:0] - mag_q;
        if (is_div) begin
            step_prod = {(div_ge ? div_sub : div_shift[BIT_W-1:0]), prod_q[BIT_W-2:0], div_ge};
        end else begin
            step_prod = {mul_sum, prod_q[BIT_W-1:1]};
        end

        prod_fix = neg_q ? -prod_q : prod_q;
        quo      = prod_q[BIT_W-1:0];
        rem      = prod_q[PROD_W-1:BIT_W];
        if (is_div) begin
            if (is_rem) fix_res = a_neg_q ? -rem : rem;
            else        fix_res = neg_q ? -quo : quo;
        end else begin
            fix_res = (op_q[1:0] == 2'd0) ? prod_fix[BIT_W-1:0] : prod_fix[PROD_W-1:BIT_W];
        end
    end

    // Next-state and register updates for the sequencer
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        mag_d    = mag_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d    = op_i;
                    rd_d    = rd_i;
                    a_d     = rs1_i;
                    b_d     = rs2_i;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (div_zero || div_ovf) begin
                    result_d = special_res;
                    rd_out_d = rd_q;
                    state_d  = S_DONE;
                end else begin
                    mag_d   = is_div ? b_mag : a_mag;
                    prod_d  = {BIT_W'(0), (is_div ? a_mag : b_mag)};
                    neg_d   = a_neg ^ b_neg;
                    a_neg_d = a_neg;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d = step_prod;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_res;
                    rd_out_d = rd_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset is asynchronous, asserted high
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mag_q    <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mag_q    <= mag_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    // Pipeline hold: raised on the accepting cycle and while working, never in reset
    always_comb begin
        stall_o = !rst_n && (((state_q == S_IDLE) && start_i && !flush_i) ||
                             (state_q == S_PREP) || (state_q == S_CALC) ||
                             (state_q == S_FIX));
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
    assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: table-driven and randomized checks of mdu_seq against an arithmetic model.
module tb_mdu_seq;
    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int n_cmp;
    int n_bad;

    mdu_seq #(.BIT_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .rd_i     (rd_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // RV32M semantics in plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic   ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
        return 35;
    endfunction

    // Issue one op in the current cycle (caller sits just after a rising edge, block IDLE)
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat,
                          input bit hold, input string nm);
        int cyc;
        bit seen;
        bit stall_bad;
        op_i = op; rs1_i = a; rs2_i = b; rd_i = rd; start_i = 1'b1;
        #1;
        chk({nm, " stall_c0"}, 32'(stall_o), 32'd1);
        cyc = 0; seen = 1'b0; stall_bad = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (!hold) start_i = 1'b0;
            if (done_o) seen = 1'b1;
            else if (!stall_o) stall_bad = 1'b1;
        end
        start_i = 1'b0;
        chk({nm, " done_seen"}, 32'(seen), 32'd1);
        chk({nm, " latency"}, 32'(cyc), 32'(lat));
        chk({nm, " stall_gap"}, 32'(stall_bad), 32'd0);
        chk({nm, " stall_done"}, 32'(stall_o), 32'd0);
        chk({nm, " result"}, result_o, exp);
        chk({nm, " rd"}, 32'(rd_o), 32'(rd));
        @(posedge clk); #1;
        chk({nm, " idle_busy"}, 32'(busy_o), 32'd0);
        chk({nm, " done_pulse"}, 32'(done_o), 32'd0);
        chk({nm, " result_held"}, result_o, exp);
    endtask

    // Start an op, flush it in cycle fc; result must not move and no done may appear
    task automatic flush_at(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int fc, input string nm);
        logic [31:0] prev;
        logic [4:0]  prev_rd;
        int          dones;
        prev = result_o; prev_rd = rd_o; dones = 0;
        op_i = op; rs1_i = a; rs2_i = b; rd_i = 5'd31; start_i = 1'b1;
        for (int c = 0; c < fc; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (done_o) dones++;
        end
        chk({nm, " busy_pre"}, 32'(busy_o), 32'd1);
        flush_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        start_i = 1'b0;
        #1;
        chk({nm, " busy"}, 32'(busy_o), 32'd0);
        chk({nm, " stall"}, 32'(stall_o), 32'd0);
        chk({nm, " done"}, 32'(dones + int'(done_o)), 32'd0);
        chk({nm, " result"}, result_o, prev);
        chk({nm, " rd"}, 32'(rd_o), 32'(prev_rd));
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        clk = 1'b0; rst_n = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        op_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;

        vt[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35};
        vt[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35};
        vt[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35};
        vt[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35};
        vt[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 35};
        vt[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 35};
        vt[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        35};
        vt[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         35};
        vt[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 2};
        vt[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         2};
        vt[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
        vt[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2};

        // Reset state, with start_i high to show stall_o stays low in reset
        repeat (2) @(posedge clk);
        #1;
        start_i = 1'b1;
        #1;
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
        chk("rst result", result_o, 32'd0);
        chk("rst rd", 32'(rd_o), 32'd0);
        chk("rst stall", 32'(stall_o), 32'd0);
        start_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, 5'(i + 1), vt[i].exp, vt[i].lat, 1'b0,
                   $sformatf("vec%0d", i));
        end

        // Flush in CALC, then a start in the very next cycle is accepted
        flush_at(3'd0, 32'd9, 32'd11, 10, "flush_calc");
        run_op(3'd0, 32'd9, 32'd11, 5'd7, 32'd99, 35, 1'b0, "after_flush");
        flush_at(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 34, "flush_fix");
        flush_at(3'd5, 32'd77, 32'd0, 1, "flush_prep");

        // Reset in the middle of a DIV
        op_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd9; start_i = 1'b1;
        repeat (20) begin @(posedge clk); #1; start_i = 1'b0; end
        rst_n = 1'b1;
        #1;
        start_i = 1'b1;
        #1;
        chk("midrst busy", 32'(busy_o), 32'd0);
        chk("midrst done", 32'(done_o), 32'd0);
        chk("midrst result", result_o, 32'd0);
        chk("midrst rd", 32'(rd_o), 32'd0);
        chk("midrst stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        chk("midrst held", 32'(busy_o), 32'd0);
        start_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        run_op(3'd0, 32'd3, 32'd4, 5'd12, 32'd12, 35, 1'b0, "post_rst");

        // start_i held through the whole op gives one done only
        begin
            int extra;
            run_op(3'd7, 32'd1000, 32'd33, 5'd4, 32'd10, 35, 1'b1, "hold_start");
            extra = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (done_o) extra++;
            end
            chk("hold_start extra_done", 32'(extra), 32'd0);
        end

        // Randomized ops against the arithmetic model
        for (int i = 0; i < 200; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 15));
                4: a = 32'($urandom_range(0, 50));
                default: ;
            endcase
            run_op(op, a, b, 5'($urandom_range(0, 31)), model(op, a, b), model_lat(op, a, b),
                   1'b0, $sformatf("rnd%0d op%0d", i, op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
